fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's 8-entry FIFO (wr/Wdata in, full out) among NUM_REQ producers.
- Round-robin arbitration with burst locking: an owner keeps the port for up to MAX_BURST accepted beats.
- Stalls on full without losing the grant.
- Sits directly in front of the FIFO write side, in the same clock domain as the FIFO write clock.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: data width, matching the FIFO Wdata width.
- MAX_BURST, 4: maximum accepted beats per grant (1..16).
- TIMEOUT, 16: stall cycles before the watchdog aborts a grant. Used only with FIFO_ARB_TIMEOUT_EN.

Ports:
- clk, in, 1: single clock for all logic.
- rst, in, 1: asynchronous, active-high reset.
- req, in, NUM_REQ: per-requester request. Held high while the requester has data.
- last, in, NUM_REQ: per-requester end-of-burst marker for the current beat.
- data, in, NUM_REQ*DATA_W: per-requester write data, slice i = data[i*DATA_W +: DATA_W].
- gnt, out, NUM_REQ: registered one-hot grant, all zero when idle.
- ack, out, NUM_REQ: combinational beat-accepted strobe, ack[i] = gnt[i] & req[i] & !full.
- owner, out, $clog2(NUM_REQ): registered index of the current grantee, 0 when idle.
- wr, out, 1: FIFO write enable, |(gnt & req) & !full.
- Wdata, out, DATA_W: data slice of the granted requester, 0 when idle.
- full, in, 1: FIFO full flag.
- timeout_err, out, 1: registered one-cycle watchdog pulse. Tied 0 without the macro.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gnt=0, owner=0, beat_cnt=0.
  - rr_last=NUM_REQ-1, so requester 0 has first priority.
  - timeout_err=0 and stall_cnt=0.
  - wr and ack evaluate to 0 because gnt=0.
- Reset mid-burst drops the grant immediately. The beat in that cycle is not written, because wr is gated by gnt.
- States: IDLE and BURST.
- IDLE:
  - If any req is high, pick the first set bit searching from (rr_last+1) mod NUM_REQ upward with wrap.
  - Register gnt/owner for that requester, beat_cnt=0, go to BURST.
  - Grant latency is 1 cycle from req; no beat is accepted in IDLE.
- BURST, per cycle:
  - Accept a beat when req[owner] & !full: wr=1, ack[owner]=1, beat_cnt++.
  - The burst ends on any of: an accepted beat with last[owner]=1; an accepted beat with beat_cnt==MAX_BURST-1; req[owner]=0 (abandon, no write).
  - On burst end: rr_last=owner. If any other req is pending, re-arbitrate that same cycle excluding the old owner's priority; the new gnt takes effect next cycle with no idle gap. Otherwise go to IDLE with gnt=0.
  - A requester that is the only one pending may be re-granted back-to-back.
- full=1 in BURST: no write, beat_cnt holds, grant holds, and a last presented during the stall does not end the burst.
- Requests arriving while BURST is active are only considered at burst end.
- Other requesters' req/last/data are ignored while they are not granted.
- beat_cnt width is $clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1 when registered.
- Invariants:
  - gnt is one-hot or zero.
  - wr implies exactly one ack bit.
  - Wdata is stable against the data of non-owners.

Optional Feature:
- FIFO_ARB_TIMEOUT_EN defined: stall_cnt counts consecutive BURST cycles with full=1 and req[owner]=1. It clears on any accepted beat or grant change.
- When stall_cnt reaches TIMEOUT-1: abort the grant as an abandon (rr_last=owner, re-arbitrate) and pulse timeout_err for 1 cycle.
- Undefined: no stall counter, timeout_err is constant 0, and a grant may stall indefinitely.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - the helper function for index width;
  - the default localparams for DATA_W=8 and FIFO depth 8.
- One sub-module, rr_picker: a combinational round-robin picker. Inputs are a request vector and the last index. Outputs are a one-hot pick, its index and a valid flag. It is reused later for a read-side scheduler.

Test Plan:
- Reset priority: release rst, raise req=4'b1111 with last=1 on every beat and full=0. Expect grants 0,1,2,3,0 in order, one beat each, with a grant change every cycle after the first and no gap.
- Burst cap: MAX_BURST=4, req[2] alone, last=0, data 0x10..0x17. Expect wr for 0x10-0x13, then re-grant to 2, then 0x14-0x17. The FIFO receives 8 writes in order.
- Full stall: grant to req[1], assert full for 5 cycles mid-burst. Expect wr=0 and ack=0 during the stall, gnt held, beat_cnt unchanged. After full drops, the remaining beats land with no duplicate or lost data.
- Abandon and mid-burst reset:
  - Abandon: req[0] drops mid-burst while req[3] is pending. Expect gnt→4'b1000 next cycle with no write in the drop cycle.
  - Reset: assert rst mid-burst. Expect gnt=0 and wr=0 at once; after release, req[0] wins first.
- Timeout (macro defined, TIMEOUT=16): hold full=1 with req[2] granted. Expect timeout_err high for exactly 1 cycle after 16 stalled cycles, and the grant moves to the next pending requester. Undefined: timeout_err stays 0 for 100 cycles.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned FIFO_DEPTH    = 8;
   localparam int unsigned DEF_NUM_REQ   = 4;
   localparam int unsigned DEF_MAX_BURST = 4;
   localparam int unsigned DEF_TIMEOUT   = 16;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after last_idx, with wrap.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N = DEF_NUM_REQ
) (
   input  logic [N-1:0]          req,
   input  logic [idx_w(N)-1:0]   last_idx,
   output logic [N-1:0]          pick_oh,
   output logic [idx_w(N)-1:0]   pick_idx,
   output logic                  pick_valid
);

   localparam int unsigned IW = idx_w(N);

   int unsigned       cand;
   logic [IW-1:0]     cand_idx;

   // Scan offsets 1..N so last_idx itself is considered last.
   always_comb begin
      pick_oh    = '0;
      pick_idx   = '0;
      pick_valid = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand     = (32'(last_idx) + k) % N;
         cand_idx = IW'(cand);
         if (!pick_valid && req[cand_idx]) begin
            pick_valid         = 1'b1;
            pick_oh[cand_idx]  = 1'b1;
            pick_idx           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the shared FIFO write port.
// Optional stall watchdog enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ-1:0]           last,
   input  logic [NUM_REQ*DATA_W-1:0]    data,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           ack,
   output logic [$clog2(NUM_REQ)-1:0]   owner,
   output logic                         wr,
   output logic [DATA_W-1:0]            Wdata,
   input  logic                         full,
   output logic                         timeout_err
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned BW = $clog2(MAX_BURST) + 1;

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("fifo_wr_arbiter: NUM_REQ out of range");
   end
   if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
      $error("fifo_wr_arbiter: MAX_BURST out of range");
   end
   if (TIMEOUT < 2 || DATA_W < 1) begin : g_bad_timeout
      $error("fifo_wr_arbiter: TIMEOUT or DATA_W out of range");
   end

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]        owner_q, owner_d;
   logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
   logic [IW-1:0]        rr_last_q, rr_last_d;

   logic [NUM_REQ-1:0]   pick_req;
   logic [IW-1:0]        pick_last;
   logic [NUM_REQ-1:0]   pick_oh;
   logic [IW-1:0]        pick_idx;
   logic                 pick_valid;
   logic                 beat_ok;
   logic                 burst_end;
   logic                 timeout_hit;
   logic [DATA_W-1:0]    wdata_c;

   assign beat_ok = (state_q == BURST) && req[owner_q] && !full;

`ifdef FIFO_ARB_TIMEOUT_EN
   localparam int unsigned SW = idx_w(TIMEOUT);

   logic [SW-1:0] stall_cnt_q, stall_cnt_d;
   logic          timeout_err_q, timeout_err_d;
   logic          stall;

   assign stall       = (state_q == BURST) && req[owner_q] && full;
   assign timeout_hit = stall && (stall_cnt_q == SW'(TIMEOUT - 1));

   // Consecutive stalled cycles on the current grant; any grant change restarts it.
   always_comb begin
      stall_cnt_d   = '0;
      timeout_err_d = timeout_hit;
      if (stall && !burst_end) begin
         stall_cnt_d = stall_cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // A watchdog abort behaves like an abandon, so the stalled owner is masked out.
   always_comb begin
      pick_req  = req;
      pick_last = rr_last_q;
      if (state_q == BURST) begin
         pick_last = owner_q;
         if (timeout_hit) begin
            pick_req = req & ~gnt_q;
         end
      end
   end

   rr_picker #(
      .N (NUM_REQ)
   ) u_picker (
      .req        (pick_req),
      .last_idx   (pick_last),
      .pick_oh    (pick_oh),
      .pick_idx   (pick_idx),
      .pick_valid (pick_valid)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      rr_last_d  = rr_last_q;
      burst_end  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d    = BURST;
               gnt_d      = pick_oh;
               owner_d    = pick_idx;
               beat_cnt_d = '0;
            end
         end
         BURST: begin
            if (beat_ok) begin
               if (last[owner_q] || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
                  burst_end = 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + BW'(1);
               end
            end else if (!req[owner_q] || timeout_hit) begin
               burst_end = 1'b1;
            end
            // Hand over in the same cycle so the next owner starts without a gap.
            if (burst_end) begin
               rr_last_d  = owner_q;
               beat_cnt_d = '0;
               if (pick_valid) begin
                  gnt_d   = pick_oh;
                  owner_d = pick_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  owner_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         rr_last_q  <= IW'(NUM_REQ - 1);
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         rr_last_q  <= rr_last_d;
      end
   end

   // One-hot grant selects the data slice; zero grant yields zero data.
   always_comb begin
      wdata_c = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (gnt_q[i]) begin
            wdata_c = wdata_c | data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign ack   = gnt_q & req & {NUM_REQ{~full}};
   assign wr    = (|(gnt_q & req)) & ~full;
   assign Wdata = wdata_c;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (4 requesters, 8-bit data, MAX_BURST 4).
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  last;
      logic        full;
      logic [31:0] data;
      logic [3:0]  e_gnt;
      logic [1:0]  e_owner;
      logic        e_wr;
      logic [7:0]  e_wdata;
      logic [3:0]  e_ack;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  last;
   logic [31:0] data;
   logic        full;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic [1:0]  owner;
   logic        wr;
   logic [7:0]  wdata;
   logic        timeout_err;

   int checks   = 0;
   int failures = 0;

   vec_t vq[$];

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ   (4),
      .DATA_W    (8),
      .MAX_BURST (4),
      .TIMEOUT   (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .last        (last),
      .data        (data),
      .gnt         (gnt),
      .ack         (ack),
      .owner       (owner),
      .wr          (wr),
      .Wdata       (wdata),
      .full        (full),
      .timeout_err (timeout_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic f,
                               input logic [31:0] d, input logic [3:0] g, input logic [1:0] o,
                               input logic w, input logic [7:0] wd, input logic [3:0] a);
      vec_t v;
      v.req = r; v.last = l; v.full = f; v.data = d;
      v.e_gnt = g; v.e_owner = o; v.e_wr = w; v.e_wdata = wd; v.e_ack = a;
      return v;
   endfunction

   initial begin
      logic [31:0] da;
      da = 32'hA3A2_A1A0;

      // Reset priority: one beat each, grant rotates 0,1,2,3,0 without gaps.
      vq.push_back(mk(4'hF, 4'hF, 0, da, 4'h0, 0, 0, 8'h00, 4'h0));
      vq.push_back(mk(4'hF, 4'hF, 0, da, 4'h1, 0, 1, 8'hA0, 4'h1));
      vq.push_back(mk(4'hF, 4'hF, 0, da, 4'h2, 1, 1, 8'hA1, 4'h2));
      vq.push_back(mk(4'hF, 4'hF, 0, da, 4'h4, 2, 1, 8'hA2, 4'h4));
      vq.push_back(mk(4'hF, 4'hF, 0, da, 4'h8, 3, 1, 8'hA3, 4'h8));
      vq.push_back(mk(4'hF, 4'hF, 0, da, 4'h1, 0, 1, 8'hA0, 4'h1));
      vq.push_back(mk(4'h0, 4'h0, 0, da, 4'h2, 1, 0, 8'hA1, 4'h0));
      // Burst cap: requester 2 alone, two capped bursts back to back.
      vq.push_back(mk(4'h4, 4'h0, 0, 32'hEE10_DDCC, 4'h0, 0, 0, 8'h00, 4'h0));
      for (int v = 8'h10; v <= 8'h17; v++)
         vq.push_back(mk(4'h4, 4'h0, 0, {8'hEE, 8'(v), 8'hDD, 8'hCC}, 4'h4, 2, 1, 8'(v), 4'h4));
      vq.push_back(mk(4'h0, 4'h0, 0, 32'hEE17_DDCC, 4'h4, 2, 0, 8'h17, 4'h0));
      // Full stall on requester 1; last and other requests during the stall are ignored.
      vq.push_back(mk(4'h2, 4'h0, 0, 32'h3344_2055, 4'h0, 0, 0, 8'h00, 4'h0));
      vq.push_back(mk(4'h2, 4'h0, 0, 32'h3344_2055, 4'h2, 1, 1, 8'h20, 4'h2));
      vq.push_back(mk(4'h3, 4'h0, 1, 32'h3344_2155, 4'h2, 1, 0, 8'h21, 4'h0));
      vq.push_back(mk(4'h3, 4'h3, 1, 32'h3344_2155, 4'h2, 1, 0, 8'h21, 4'h0));
      vq.push_back(mk(4'h3, 4'h3, 1, 32'h3344_2155, 4'h2, 1, 0, 8'h21, 4'h0));
      vq.push_back(mk(4'h3, 4'h0, 1, 32'h3344_2155, 4'h2, 1, 0, 8'h21, 4'h0));
      vq.push_back(mk(4'h3, 4'h0, 1, 32'h3344_2155, 4'h2, 1, 0, 8'h21, 4'h0));
      vq.push_back(mk(4'h3, 4'h0, 0, 32'h3344_2155, 4'h2, 1, 1, 8'h21, 4'h2));
      vq.push_back(mk(4'h3, 4'h0, 0, 32'h3344_2255, 4'h2, 1, 1, 8'h22, 4'h2));
      vq.push_back(mk(4'h3, 4'h0, 0, 32'h3344_2355, 4'h2, 1, 1, 8'h23, 4'h2));
      // Abandon: requester 0 drops mid-burst, requester 3 takes over next cycle.
      vq.push_back(mk(4'h9, 4'h0, 0, 32'h3F77_8830, 4'h1, 0, 1, 8'h30, 4'h1));
      vq.push_back(mk(4'h8, 4'h0, 0, 32'h3F77_8830, 4'h1, 0, 0, 8'h30, 4'h0));
      vq.push_back(mk(4'h8, 4'h8, 0, 32'h3F77_8830, 4'h8, 3, 1, 8'h3F, 4'h8));
      vq.push_back(mk(4'h0, 4'h0, 0, 32'h3F77_8830, 4'h8, 3, 0, 8'h3F, 4'h0));
      vq.push_back(mk(4'h0, 4'h0, 0, 32'h3F77_8830, 4'h0, 0, 0, 8'h00, 4'h0));

      rst = 1'b1; req = '0; last = '0; data = '0; full = 1'b0;
      step();
      chk("reset gnt", 32'(gnt), 32'h0);
      chk("reset owner", 32'(owner), 32'h0);
      chk("reset wr", 32'(wr), 32'h0);
      chk("reset ack", 32'(ack), 32'h0);
      chk("reset timeout_err", 32'(timeout_err), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         req = vq[i].req; last = vq[i].last; full = vq[i].full; data = vq[i].data;
         #1;
         chk($sformatf("vec%0d gnt", i),   32'(gnt),   32'(vq[i].e_gnt));
         chk($sformatf("vec%0d owner", i), 32'(owner), 32'(vq[i].e_owner));
         chk($sformatf("vec%0d wr", i),    32'(wr),    32'(vq[i].e_wr));
         chk($sformatf("vec%0d Wdata", i), 32'(wdata), 32'(vq[i].e_wdata));
         chk($sformatf("vec%0d ack", i),   32'(ack),   32'(vq[i].e_ack));
         step();
      end

      // Mid-burst reset: grant and write drop at once, requester 0 wins afterwards.
      req = 4'h2; last = 4'h2; data = 32'h0000_5500; full = 1'b0;
      step();
      chk("pre-rst gnt1", 32'(gnt), 32'h2);
      chk("pre-rst wdata1", 32'(wdata), 32'h55);
      step();
      req = 4'h4; last = 4'h0; data = 32'h0066_5500;
      #1;
      chk("pre-rst abandon wr", 32'(wr), 32'h0);
      step();
      chk("pre-rst gnt2", 32'(gnt), 32'h4);
      chk("pre-rst wr2", 32'(wr), 32'h1);
      rst = 1'b1;
      #1;
      chk("mid-rst gnt", 32'(gnt), 32'h0);
      chk("mid-rst wr", 32'(wr), 32'h0);
      chk("mid-rst ack", 32'(ack), 32'h0);
      step();
      rst = 1'b0; req = 4'hF; last = 4'hF; data = da;
      #1;
      chk("post-rst idle gnt", 32'(gnt), 32'h0);
      step();
      chk("post-rst first gnt", 32'(gnt), 32'h1);
      chk("post-rst first wdata", 32'(wdata), 32'hA0);
      req = 4'h0; last = 4'h0;
      step();
      step();

      // Watchdog: requester 2 stalled behind full, requester 3 pending.
      rst = 1'b1;
      step();
      rst = 1'b0; req = 4'hC; last = 4'h0; full = 1'b1; data = 32'h9988_7766;
      #1;
      chk("to idle gnt", 32'(gnt), 32'h0);
      step();
      for (int s = 1; s <= 16; s++) begin
         chk($sformatf("stall%0d gnt", s), 32'(gnt), 32'h4);
         chk($sformatf("stall%0d wr", s), 32'(wr), 32'h0);
         chk($sformatf("stall%0d timeout_err", s), 32'(timeout_err), 32'h0);
         step();
      end
`ifdef FIFO_ARB_TIMEOUT_EN
      chk("timeout pulse", 32'(timeout_err), 32'h1);
      chk("timeout new gnt", 32'(gnt), 32'h8);
      step();
      chk("timeout pulse end", 32'(timeout_err), 32'h0);
      chk("timeout gnt held", 32'(gnt), 32'h8);
`else
      for (int s = 17; s <= 100; s++) begin
         chk($sformatf("stall%0d timeout_err", s), 32'(timeout_err), 32'h0);
         chk($sformatf("stall%0d gnt", s), 32'(gnt), 32'h4);
         step();
      end
`endif
      full = 1'b0; req = 4'h0;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
